ps2_host_tx: RTL

- Host-to-device PS/2 transmitter, the outbound direction of the keyboard link. The inbound scancode receiver already decodes the up-arrow jump key on PS2_CLK/PS2_DAT.
- Sends one command byte to the keyboard, e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable. Performs the inhibit / request-to-send sequence, shifts 8 data bits, odd parity and stop, then checks the device ACK.
- Drives the open-collector pins through output-enables. The top level ties PS2_CLK = clk_oe ? 0 : 1'bz, and likewise for PS2_DAT.

---
 rtl/ps2_host_tx.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 8 data bits, odd parity, stop,
// device ACK check. Open-collector pins are driven through registered output enables.
module ps2_host_tx #(
   parameter int unsigned INHIBIT_CYCLES = 5000,
   parameter int unsigned EDGE_TIMEOUT   = 750000,
   parameter int unsigned FILTER_LEN     = 4
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe,
   output logic       tx_done,
   output logic       tx_error,
   output logic       busy
);

   localparam int unsigned TMAX = (EDGE_TIMEOUT > INHIBIT_CYCLES) ? EDGE_TIMEOUT : INHIBIT_CYCLES;
   localparam int unsigned TW   = $clog2(TMAX + 1);
   localparam int unsigned FW   = $clog2(FILTER_LEN + 1);

   typedef enum logic [2:0] {StIdle, StInhibit, StSend, StAck, StWaitIdle, StError} state_e;

   logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
   logic          clk_f_q;
   logic [FW-1:0] filt_cnt_q;
   logic          fall;

   state_e        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [3:0]    bitcnt_q, bitcnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_q, par_d;
   logic          clk_oe_q, clk_oe_d;
   logic          dat_oe_q, dat_oe_d;
   logic          done_q, done_d;

   // Synchronisers idle high so a released bus looks quiet straight out of reset
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         clk_s1_q   <= 1'b1;
         clk_s2_q   <= 1'b1;
         dat_s1_q   <= 1'b1;
         dat_s2_q   <= 1'b1;
         clk_f_q    <= 1'b1;
         filt_cnt_q <= '0;
      end else begin
         clk_s1_q <= ps2_clk_in;
         clk_s2_q <= clk_s1_q;
         dat_s1_q <= ps2_dat_in;
         dat_s2_q <= dat_s1_q;
         if (clk_s2_q == clk_f_q) begin
            filt_cnt_q <= '0;
         end else if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
            clk_f_q    <= clk_s2_q;
            filt_cnt_q <= '0;
         end else begin
            filt_cnt_q <= filt_cnt_q + 1'b1;
         end
      end
   end

   // Asserted in the cycle whose edge drops the filtered clock, so the FSM acts on that edge
   assign fall = clk_f_q && !clk_s2_q && (filt_cnt_q == FW'(FILTER_LEN - 1));

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q  <= StIdle;
         timer_q  <= '0;
         bitcnt_q <= '0;
         shift_q  <= '0;
         par_q    <= 1'b0;
         clk_oe_q <= 1'b0;
         dat_oe_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         bitcnt_q <= bitcnt_d;
         shift_q  <= shift_d;
         par_q    <= par_d;
         clk_oe_q <= clk_oe_d;
         dat_oe_q <= dat_oe_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      bitcnt_d = bitcnt_q;
      shift_d  = shift_q;
      par_d    = par_q;
      clk_oe_d = clk_oe_q;
      dat_oe_d = dat_oe_q;
      done_d   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (tx_valid) begin
               shift_d  = tx_data;
               par_d    = ~^tx_data;
               clk_oe_d = 1'b1;
               dat_oe_d = 1'b0;
               timer_d  = '0;
               state_d  = StInhibit;
            end
         end
         StInhibit: begin
            timer_d = timer_q + 1'b1;
            if (timer_q == TW'(INHIBIT_CYCLES - 2)) dat_oe_d = 1'b1;
            if (timer_q == TW'(INHIBIT_CYCLES - 1)) begin
               clk_oe_d = 1'b0;
               bitcnt_d = '0;
               timer_d  = '0;
               state_d  = StSend;
            end
         end
         StSend: begin
            if (fall) begin
               timer_d  = '0;
               bitcnt_d = bitcnt_q + 1'b1;
               if (bitcnt_q < 4'd8) begin
                  dat_oe_d = ~shift_q[bitcnt_q[2:0]];
               end else if (bitcnt_q == 4'd8) begin
                  dat_oe_d = ~par_q;
               end else begin
                  dat_oe_d = 1'b0;
                  state_d  = StAck;
               end
            end else if (timer_q == TW'(EDGE_TIMEOUT - 1)) begin
               clk_oe_d = 1'b0;
               dat_oe_d = 1'b0;
               state_d  = StError;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         StAck: begin
            if (fall) begin
               timer_d = '0;
               state_d = dat_s2_q ? StError : StWaitIdle;
            end else if (timer_q == TW'(EDGE_TIMEOUT - 1)) begin
               state_d = StError;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         StWaitIdle: begin
            if (clk_f_q && dat_s2_q) begin
               done_d  = 1'b1;
               state_d = StIdle;
            end else if (fall) begin
               timer_d = '0;
            end else if (timer_q == TW'(EDGE_TIMEOUT - 1)) begin
               state_d = StError;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         StError: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_comb begin
      tx_ready   = (state_q == StIdle);
      busy       = (state_q != StIdle);
      tx_done    = done_q;
      tx_error   = (state_q == StError);
      ps2_clk_oe = clk_oe_q;
      ps2_dat_oe = dat_oe_q;
   end

endmodule
